// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing one AHB-to-peripheral bridge among NUM_MASTERS requesters,
// with per-grant burst limit, address/data muxing, done/error pulses and a stall watchdog.
module ahb_bridge_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                            hclk,
  input  logic                            hresetn,
  input  logic [NUM_MASTERS-1:0]          m_hbusreq,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_haddr,
  input  logic [NUM_MASTERS-1:0]          m_hwrite,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_hwdata,
  output logic [NUM_MASTERS-1:0]          m_hgrant,
  output logic [NUM_MASTERS-1:0]          m_done,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic [$clog2(NUM_MASTERS)-1:0]  hmaster,
  output logic                            s_hsel,
  output logic [ADDR_W-1:0]               s_haddr,
  output logic                            s_hwrite,
  output logic [DATA_W-1:0]               s_hwdata,
  output logic                            s_hready,
  input  logic                            s_hreadyout,
  input  logic                            s_hresp
);

  localparam int MW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, REL} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] done_q, done_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic [MW-1:0]          rr_q, rr_d;
  logic [3:0]             count_q, count_d;
  logic [7:0]             timer_q, timer_d;

  logic [MW-1:0]          win_idx;
  logic                   win_found;
  int unsigned            cand;
  logic                   burst_more;

  // First requester strictly after the last-served master, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = (32'(rr_q) + i) % NUM_MASTERS;
      if (!win_found && m_hbusreq[MW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = MW'(cand);
      end
    end
  end

  assign burst_more = m_hbusreq[hmaster_q] &&
                      (({1'b0, count_q} + 5'd1) < 5'(MAX_BURST));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    hmaster_d = hmaster_q;
    rr_d      = rr_q;
    count_d   = count_q;
    timer_d   = timer_q;
    done_d    = '0;
    err_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = GRANT;
          hmaster_d = win_idx;
          grant_d   = NUM_MASTERS'(1) << win_idx;
        end
      end
      GRANT: begin
        count_d = '0;
        timer_d = '0;
        state_d = XFER;
      end
      XFER: begin
        if (s_hresp) begin
          err_d[hmaster_q] = 1'b1;
          state_d          = REL;
        end else if (s_hreadyout) begin
          done_d[hmaster_q] = 1'b1;
          count_d           = count_q + 4'd1;
          timer_d           = '0;
          if (!burst_more) state_d = REL;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          err_d[hmaster_q] = 1'b1;
          state_d          = REL;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      REL: begin
        // Grant is held through the turnaround cycle and drops on entry to IDLE.
        grant_d = '0;
        rr_d    = hmaster_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      hmaster_q <= '0;
      rr_q      <= MW'(NUM_MASTERS - 1);
      count_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      hmaster_q <= hmaster_d;
      rr_q      <= rr_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    s_hsel   = (state_q == XFER);
    s_hready = s_hsel;
    s_haddr  = '0;
    s_hwrite = 1'b0;
    s_hwdata = '0;
    if (s_hsel) begin
      s_haddr  = m_haddr[int'(hmaster_q) * ADDR_W +: ADDR_W];
      s_hwrite = m_hwrite[hmaster_q];
      s_hwdata = m_hwdata[int'(hmaster_q) * DATA_W +: DATA_W];
    end
  end

  assign m_hgrant = grant_q;
  assign m_done   = done_q;
  assign m_err    = err_q;
  assign hmaster  = hmaster_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Bench for ahb_bridge_arbiter: directed scenarios plus randomized traffic,
// all cycles checked against a transaction-level reference model.
module tb_ahb_bridge_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int TO = 16;

  logic              hclk = 1'b0;
  logic              hresetn;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   haddr;
  logic [N-1:0]      hwrite;
  logic [N*DW-1:0]   hwdata;
  logic [N-1:0]      m_hgrant, m_done, m_err;
  logic [1:0]        hmaster;
  logic              s_hsel, s_hwrite, s_hready;
  logic [AW-1:0]     s_haddr;
  logic [DW-1:0]     s_hwdata;
  logic              hreadyout, hresp;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_bridge_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO)
  ) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m_hbusreq(req), .m_haddr(haddr), .m_hwrite(hwrite), .m_hwdata(hwdata),
    .m_hgrant(m_hgrant), .m_done(m_done), .m_err(m_err), .hmaster(hmaster),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hreadyout(hreadyout), .s_hresp(hresp)
  );

  always #5 hclk = ~hclk;

  // Reference model: who owns the bridge, how far into its tenure, beats and stall run length.
  int           md_owner, md_rr, md_age, md_beats, md_wait;
  bit           md_granted, md_release;
  logic [N-1:0] md_done, md_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    md_owner = 0; md_rr = N - 1; md_age = 0; md_beats = 0; md_wait = 0;
    md_granted = 0; md_release = 0; md_done = '0; md_err = '0;
  endtask

  task automatic model_advance();
    bit found;
    md_done = '0;
    md_err  = '0;
    if (!md_granted) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (md_rr + k) % N;
        if (!found && req[c]) begin
          found = 1; md_owner = c; md_granted = 1; md_age = 0; md_release = 0;
        end
      end
    end else if (md_release) begin
      md_granted = 0; md_release = 0; md_rr = md_owner;
    end else if (md_age == 0) begin
      md_age = 1; md_beats = 0; md_wait = 0;
    end else begin
      if (hresp) begin
        md_err[md_owner] = 1'b1; md_release = 1;
      end else if (hreadyout) begin
        md_done[md_owner] = 1'b1;
        md_beats++;
        md_wait = 0;
        if (!(req[md_owner] && md_beats < MB)) md_release = 1;
      end else begin
        md_wait++;
        if (md_wait == TO) begin
          md_err[md_owner] = 1'b1; md_release = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    bit           esel;
    eg   = md_granted ? (N'(1) << md_owner) : '0;
    esel = md_granted && !md_release && md_age >= 1;
    check("grant", m_hgrant, eg);
    check("hmaster", hmaster, md_owner);
    check("hsel", s_hsel, esel);
    check("hready", s_hready, esel);
    check("done", m_done, md_done);
    check("err", m_err, md_err);
    if (esel) begin
      check("haddr", s_haddr, haddr[md_owner*AW +: AW]);
      check("hwrite", s_hwrite, hwrite[md_owner]);
      check("hwdata", s_hwdata, hwdata[md_owner*DW +: DW]);
    end
  endtask

  task automatic tick();
    if (hresetn) model_advance(); else model_reset();
    @(posedge hclk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    req = '0;
    hresetn = 1'b0;
    model_reset();
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hresetn = 1'b1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      haddr[i*AW +: AW]  = $urandom;
      hwdata[i*DW +: DW] = $urandom;
    end
    hwrite = N'($urandom);
  endtask

  task automatic wait_grant(input int idx, input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (m_hgrant[idx]) got = 1;
    end
    check(tag, got, 1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int dones, errs, sels, stall_left;
    bit dropped;

    hresetn = 1'b0; hreadyout = 1'b0; hresp = 1'b0;
    rand_data();
    req = '1;
    model_reset();
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    check("rst_grant", m_hgrant, 0);
    check("rst_done", m_done, 0);
    check("rst_err", m_err, 0);
    check("rst_hmaster", hmaster, 0);
    check("rst_hsel", s_hsel, 0);
    check("rst_hready", s_hready, 0);
    check("rst_haddr", s_haddr, 0);
    check("rst_hwdata", s_hwdata, 0);
    check("rst_hwrite", s_hwrite, 0);
    req = '0;
    hresetn = 1'b1;
    drain(2);

    // Single write from m0 with immediate acceptance.
    haddr[0 +: AW] = 32'h100; hwdata[0 +: DW] = 32'hDEAD; hwrite[0] = 1'b1;
    req = 4'b0001; hreadyout = 1'b1;
    tick(); check("t1_grant", m_hgrant, 4'b0001); check("t1_nosel", s_hsel, 0);
    tick(); check("t1_sel", s_hsel, 1); check("t1_addr", s_haddr, 32'h100);
    check("t1_wdata", s_hwdata, 32'hDEAD); check("t1_write", s_hwrite, 1);
    req = '0;
    tick(); check("t1_done", m_done, 4'b0001); check("t1_grant_hold", m_hgrant, 4'b0001);
    tick(); check("t1_grant_drop", m_hgrant, 0);
    drain(2);

    // m1 and m2 together from reset: m1, then m2, then m1 again.
    do_reset();
    req = 4'b0110;
    tick(); check("t2_first_m1", m_hgrant, 4'b0010);
    tick(); check("t2_sel1", s_hsel, 1);
    req = 4'b0100;
    tick(); check("t2_done1", m_done, 4'b0010);
    req = 4'b0110;
    tick(); check("t2_idle_gap", m_hgrant, 0);
    tick(); check("t2_then_m2", m_hgrant, 4'b0100);
    tick();
    req = 4'b0010;
    tick(); check("t2_done2", m_done, 4'b0100);
    tick();
    tick(); check("t2_back_m1", m_hgrant, 4'b1 << 1);
    req = '0;
    drain(4);

    // m3 holds its request: burst limited to MB transfers, then re-granted.
    req = 4'b1000; hreadyout = 1'b1;
    wait_grant(3, "t3_grant_wait");
    dones = 0; dropped = 0;
    for (int i = 0; i < 30 && !dropped; i++) begin
      tick();
      if (m_done[3]) dones++;
      if (m_hgrant == 0) dropped = 1;
    end
    check("t3_released", dropped, 1);
    check("t3_burst_len", dones, MB);
    tick(); check("t3_regrant", m_hgrant, 4'b1000);
    req = '0;
    drain(6);

    // m0 with the bridge stalled: watchdog abort.
    req = 4'b0001; hreadyout = 1'b0;
    wait_grant(0, "t4_grant_wait");
    sels = 0; errs = 0; dones = 0; dropped = 0;
    for (int i = 0; i < TO + 10 && !dropped; i++) begin
      tick();
      if (s_hsel) begin sels++; req = '0; end
      if (m_err[0]) errs++;
      if (m_done != 0) dones++;
      if (m_hgrant == 0) dropped = 1;
    end
    check("t4_stall_cycles", sels, TO);
    check("t4_err_pulses", errs, 1);
    check("t4_no_done", dones, 0);
    check("t4_released", dropped, 1);
    hreadyout = 1'b1;
    drain(3);

    // Error response together with hreadyout on m2.
    req = 4'b0100; hresp = 1'b1;
    wait_grant(2, "t5_grant_wait");
    tick(); check("t5_sel", s_hsel, 1);
    tick(); check("t5_err", m_err, 4'b0100); check("t5_no_done", m_done, 0);
    tick(); check("t5_released", m_hgrant, 0);
    req = '0; hresp = 1'b0;
    drain(3);

    // Asynchronous reset during XFER.
    req = 4'b0010; hreadyout = 1'b0;
    wait_grant(1, "t6_grant_wait");
    tick(); check("t6_sel", s_hsel, 1);
    #3;
    hresetn = 1'b0;
    model_reset();
    #1;
    check("t6_async_sel", s_hsel, 0);
    check("t6_async_grant", m_hgrant, 0);
    check("t6_async_err", m_err, 0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    req = 4'b1111; hreadyout = 1'b1;
    tick(); check("t6_m0_priority", m_hgrant, 4'b0001);

    // Randomized traffic with occasional long stalls and error responses.
    stall_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rand_data();
      req = N'($urandom) & N'($urandom | $urandom);
      if (stall_left == 0 && $urandom_range(0, 39) == 0) stall_left = $urandom_range(8, 24);
      if (stall_left > 0) begin
        hreadyout = 1'b0;
        stall_left--;
      end else begin
        hreadyout = ($urandom_range(0, 9) < 6);
      end
      hresp = ($urandom_range(0, 24) == 0);
      tick();
      check("pulse_excl", m_done & m_err, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
